// File: rtl/out_checker_if.sv
// Executor-to-checker out-word stream: valid/ready handshake plus the
// executor's completion level.
interface out_checker_if #(
    parameter int unsigned MemoryElementWidth = 12
);
    logic                          outValid;
    logic [MemoryElementWidth-1:0] outData;
    logic                          outReady;
    logic                          progDone;

    modport master (
        output outValid,
        output outData,
        output progDone,
        input  outReady
    );

    modport slave (
        input  outValid,
        input  outData,
        input  progDone,
        output outReady
    );
endinterface

// File: rtl/out_checker.sv
// Compares the executor's out-word stream against a preloaded expected-value
// table through a small input FIFO, then reports pass/fail and error stats.
module out_checker #(
    parameter int unsigned MemoryElementWidth = 12,
    parameter int unsigned NExpect            = 32,
    parameter int unsigned FifoDepth          = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             expWrite,
    input  logic [$clog2(NExpect)-1:0]       expAddr,
    input  logic [MemoryElementWidth-1:0]    expData,
    input  logic [$clog2(NExpect+1)-1:0]     expCount,
    input  logic                             start,
    out_checker_if.slave                     outBus,
    input  logic                             hold,
    output logic                             finished,
    output logic                             success,
    output logic [7:0]                       received,
    output logic [7:0]                       mismatches,
    output logic [7:0]                       firstBad
);
    localparam int unsigned IdxW = $clog2(NExpect);
    localparam int unsigned CntW = $clog2(NExpect + 1);
    localparam int unsigned PtrW = $clog2(FifoDepth);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                        state;
    logic [MemoryElementWidth-1:0] expTable [NExpect];
    logic [MemoryElementWidth-1:0] fifoMem [FifoDepth];
    logic [PtrW-1:0]               rdPtr;
    logic [PtrW-1:0]               wrPtr;
    logic [PtrW:0]                 fill;
    logic [CntW-1:0]               expLatched;
    logic [7:0]                    popCount;

    logic                          fifoFull;
    logic                          fifoEmpty;
    logic                          push;
    logic                          pop;
    logic                          popBad;
    logic [MemoryElementWidth-1:0] expWord;

    always_comb begin
        fifoFull        = (fill == (PtrW+1)'(FifoDepth));
        fifoEmpty       = (fill == '0);
        outBus.outReady = (state == RUN) && !fifoFull;
        push            = outBus.outValid && outBus.outReady;
        pop             = !fifoEmpty && !hold && ((state == RUN) || (state == DRAIN));
        // Indices past the table are always mismatches, so the truncated read is harmless there.
        expWord         = expTable[popCount[IdxW-1:0]];
        popBad          = (popCount >= 8'(expLatched)) || (fifoMem[rdPtr] != expWord);
    end

    // Storage arrays carry no reset so the table survives a reset.
    always_ff @(posedge clock) begin
        if ((state == IDLE) && expWrite) begin
            expTable[expAddr] <= expData;
        end
        if (push) begin
            fifoMem[wrPtr] <= outBus.outData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rdPtr      <= '0;
            wrPtr      <= '0;
            fill       <= '0;
            expLatched <= '0;
            popCount   <= '0;
            finished   <= 1'b0;
            success    <= 1'b0;
            received   <= '0;
            mismatches <= '0;
            firstBad   <= '1;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PtrW'(1);
                if (received != '1) begin
                    received <= received + 8'd1;
                end
            end

            if (pop) begin
                rdPtr <= rdPtr + PtrW'(1);
                if (popCount != '1) begin
                    popCount <= popCount + 8'd1;
                end
                if (popBad) begin
                    if (mismatches == '0) begin
                        firstBad <= popCount;
                    end
                    if (mismatches != '1) begin
                        mismatches <= mismatches + 8'd1;
                    end
                end
            end

            if (push && !pop) begin
                fill <= fill + (PtrW+1)'(1);
            end else if (pop && !push) begin
                fill <= fill - (PtrW+1)'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        expLatched <= (expCount > CntW'(NExpect)) ? CntW'(NExpect) : expCount;
                        popCount   <= '0;
                        received   <= '0;
                        mismatches <= '0;
                        firstBad   <= '1;
                        finished   <= 1'b0;
                        success    <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (outBus.progDone) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifoEmpty) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        success  <= (mismatches == '0) && (popCount == 8'(expLatched));
                    end
                end
                DONE: begin
                end
            endcase
        end
    end
endmodule
